tnn_popcount_accum: RTL and testbench
=====================================

# tnn_popcount_accum

Sequential accumulation stage directly downstream of the 14-input approximate popcount units in the ternary neural network (TNN) datapath. Each beat it takes one positive-match and one negative-match 4-bit popcount, accumulates their signed difference over a fixed number of beats (one neuron's fan-in = 14·BEATS synapses), and compares the total against two thresholds. The result is a ternary activation {-1, 0, +1} for the next layer, delivered with valid/ready handshakes on both sides.

## Interface
- BEATS, 8: beats per neuron (≥2); fan-in = 14·BEATS.
- CNT_W, 4: popcount input width; fixed to the popcount output width.
- ACC_W, derived localparam = $clog2(15·BEATS+1)+1: signed accumulator width. Sized for the 4-bit code maximum 15, not 14, because approximate popcounts can emit 15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous abort of the current accumulation.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_pos  in  CNT_W  unsigned popcount of +1 weight matches.
- in_neg  in  CNT_W  unsigned popcount of -1 weight matches.
- thr_hi  in  ACC_W  signed upper threshold; quasi-static.
- thr_lo  in  ACC_W  signed lower threshold; quasi-static; thr_lo ≤ thr_hi.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_tern  out  2  2'b01 = +1, 2'b00 = 0, 2'b11 = -1.
- out_sum  out  ACC_W  signed final accumulated sum, for debug and test.

## Operation
- **FSM states**
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: out_valid=1, in_ready=out_ready.
- **Accepted beat:** acc += zero-extend(in_pos) − zero-extend(in_neg), computed at ACC_W; beat_cnt increments.
- **First beat of a neuron:** acc loads in_pos − in_neg; no separate clear cycle is needed.
- **Final beat** (beat_cnt == BEATS−1):
  - The final sum is registered into out_sum.
  - out_tern is computed from the final sum: +1 if sum > thr_hi, −1 if sum < thr_lo, else 0.
  - beat_cnt wraps to 0 and the FSM goes to DONE.
- **DONE with out_ready=1:** the result is consumed. A beat presented in the same cycle is accepted as beat 0 of the next neuron, giving back-to-back operation with no bubble.
  - If that beat is also the final beat (BEATS=1 is illegal), there is no conflict.
- **DONE with out_ready=0:** in_ready=0. out_tern and out_sum stay stable until consumed.
- **clr** has priority over everything:
  - Next state is ACCUM; beat_cnt=0; acc=0; out_valid=0.
  - Any beat handshaken in the clr cycle is discarded.
  - A held result is dropped.
- **Overflow:** none possible by construction of ACC_W; no saturation logic.

## Timing
- Reset values: state=ACCUM, beat_cnt=0, acc=0, out_valid=0, out_tern=2'b00, out_sum=0. in_ready=1 from the first cycle after rst_n deasserts.
- Reset asserted mid-neuron: all state clears immediately (asynchronous); partial sums are lost.
- Latency: out_valid rises on the clock edge that accepts the final beat, so it is visible in the next cycle.
- Throughput: one beat per cycle sustained; one neuron per BEATS cycles when out_ready is held at 1.
- in_ready is a registered-state function plus out_ready (combinational path out_ready→in_ready only in DONE).
- Thresholds are sampled on the final-beat edge only; they must be stable for that cycle.

## Structure
- Shared package tnn_pkg holds:
  - ternary encodings TERN_POS=2'b01, TERN_ZERO=2'b00, TERN_NEG=2'b11;
  - a tern_t typedef;
  - the ACC_W derivation function.
- One combinational sub-module, tnn_tern_cmp (sum, thr_hi, thr_lo → tern), reused by later activation stages.
- The popcount units stay upstream and are not instantiated here.

## Test plan
All scenarios use BEATS=4 unless stated.
- **Reset:** rst_n low mid-accumulation after 2 beats → out_valid=0, out_tern=00, in_ready=1. The next 4 beats of pos=1, neg=0 yield out_sum=4.
- **Positive result:** thr_hi=10, thr_lo=−10; 4 beats of pos=14, neg=0 → out_sum=56, out_tern=01, out_valid the cycle after beat 4.
- **Negative result and dead band:** 4 beats of pos=0, neg=15 → out_sum=−60, out_tern=11. With the same thresholds, beats (3,1)×4 → out_sum=8, out_tern=00.
- **Backpressure and back-to-back:**
  - out_ready=0 for 5 cycles: in_ready=0 and the result is held.
  - Raise out_ready together with a new beat: the result is consumed and the beat becomes beat 0 of the next neuron.
  - With out_ready held at 1, the next result arrives exactly 4 cycles later.
- **clr boundary:** clr asserted together with final beat 4 → no out_valid, acc=0. Assert clr while in DONE → result dropped, state returns to ACCUM.
- **Threshold equality:** sum == thr_hi → 00; sum == thr_lo → 00.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared TNN definitions: ternary activation encodings, the accumulator FSM
// state type and the accumulator width derivation.
package tnn_pkg;

    typedef logic [1:0] tern_t;

    localparam tern_t TERN_POS  = 2'b01;
    localparam tern_t TERN_ZERO = 2'b00;
    localparam tern_t TERN_NEG  = 2'b11;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } acc_state_t;

    // Signed width holding +/-15*beats. It uses 15 rather than 14 because the
    // approximate popcount units can emit the all-ones code.
    function automatic int acc_width(input int beats);
        return $clog2(15 * beats + 1) + 1;
    endfunction

endpackage

// File: rtl/tnn_tern_cmp.sv
// Two-threshold ternary quantiser: +1 above thr_hi, -1 below thr_lo, else 0.
// Both comparisons are strict, so a sum equal to either threshold maps to 0.
module tnn_tern_cmp
    import tnn_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] sum,
    input  logic [W-1:0] thr_hi,
    input  logic [W-1:0] thr_lo,
    output logic [1:0]   tern
);

    // Signed compare against both thresholds; the upper test wins if the
    // thresholds are ever misprogrammed with thr_lo > thr_hi.
    always_comb begin
        tern = TERN_ZERO;
        if ($signed(sum) > $signed(thr_hi))
            tern = TERN_POS;
        else if ($signed(sum) < $signed(thr_lo))
            tern = TERN_NEG;
    end

endmodule

// File: rtl/tnn_popcount_accum.sv
// Per-neuron accumulator: sums (pos - neg) popcounts over BEATS beats,
// quantises the total to a ternary activation and hands it downstream
// with a valid/ready handshake. A result being consumed and the first beat
// of the next neuron can share one cycle, so throughput is one beat/cycle.
module tnn_popcount_accum
    import tnn_pkg::*;
#(
    parameter  int BEATS = 8,
    parameter  int CNT_W = 4,
    localparam int ACC_W = acc_width(BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_pos,
    input  logic [CNT_W-1:0] in_neg,
    input  logic [ACC_W-1:0] thr_hi,
    input  logic [ACC_W-1:0] thr_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_tern,
    output logic [ACC_W-1:0] out_sum
);

    localparam int BC_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

    acc_state_t      state;
    logic [BC_W-1:0] beat_cnt;
    logic [ACC_W-1:0] acc;

    logic             beat_fire;
    logic             last_beat;
    logic [ACC_W-1:0] delta;
    logic [ACC_W-1:0] next_acc;
    logic [1:0]       next_tern;

    // Ready while accumulating; in DONE a beat is only taken when the held
    // result leaves in the same cycle.
    assign in_ready  = (state == ST_ACCUM) | out_ready;
    assign out_valid = (state == ST_DONE);
    assign beat_fire = in_valid & in_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Zero-extend both counts before subtracting; two's complement wrap at
    // ACC_W gives the signed difference directly.
    assign delta    = ACC_W'(in_pos) - ACC_W'(in_neg);
    // Beat 0 loads rather than adds, so no clear cycle is needed between
    // neurons.
    assign next_acc = (beat_cnt == '0) ? delta : acc + delta;

    tnn_tern_cmp #(
        .W (ACC_W)
    ) u_cmp (
        .sum    (next_acc),
        .thr_hi (thr_hi),
        .thr_lo (thr_lo),
        .tern   (next_tern)
    );

    // Accumulate/deliver FSM; clr overrides any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ACCUM;
            beat_cnt <= '0;
            acc      <= '0;
            out_tern <= TERN_ZERO;
            out_sum  <= '0;
        end else if (clr) begin
            state    <= ST_ACCUM;
            beat_cnt <= '0;
            acc      <= '0;
        end else begin
            if (state == ST_DONE && out_ready)
                state <= ST_ACCUM;
            if (beat_fire) begin
                acc <= next_acc;
                if (last_beat) begin
                    beat_cnt <= '0;
                    out_sum  <= next_acc;
                    out_tern <= next_tern;
                    state    <= ST_DONE;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tnn_popcount_accum.sv
// Directed plus random bench for tnn_popcount_accum (BEATS=4). The reference
// model keeps a list of accepted beats per neuron and a single outstanding
// result; every cycle the DUT handshake and outputs are compared to it.
module tb_tnn_popcount_accum;
    import tnn_pkg::*;

    localparam int BEATS = 4;
    localparam int AW    = acc_width(BEATS);

    logic          clk = 1'b0;
    logic          rst_n, clr, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]    in_pos, in_neg;
    logic [AW-1:0] thr_hi, thr_lo, out_sum;
    logic [1:0]    out_tern;

    int errors = 0;
    int checks = 0;

    // model state
    int beats[$];
    bit exp_have;
    int exp_sum;
    int exp_tern;
    int hi_i, lo_i;

    always #5 clk = ~clk;

    tnn_popcount_accum #(.BEATS(BEATS), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg),
        .thr_hi(thr_hi), .thr_lo(thr_lo),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tern(out_tern), .out_sum(out_sum)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tern_of(input int s, input int hi, input int lo);
        if (s > hi) return 1;
        if (s < lo) return 3;
        return 0;
    endfunction

    task automatic set_thr(input int hi, input int lo);
        hi_i = hi; lo_i = lo;
        thr_hi = AW'(hi); thr_lo = AW'(lo);
    endtask

    // One clock: apply inputs, check against the model, then advance both.
    // Entered and left 1 time unit after a rising edge.
    task automatic cyc(input bit v, input int p, input int n, input bit ordy, input bit c);
        bit fire;
        int s;
        in_valid = v; in_pos = 4'(p); in_neg = 4'(n); out_ready = ordy; clr = c;
        #1;
        chk("in_ready", int'(in_ready), int'(!exp_have || ordy));
        chk("out_valid", int'(out_valid), int'(exp_have));
        if (exp_have) begin
            chk("out_sum", int'($signed(out_sum)), exp_sum);
            chk("out_tern", int'(out_tern), exp_tern);
        end
        if (c) begin
            beats.delete();
            exp_have = 0;
        end else begin
            fire = v && (!exp_have || ordy);
            if (exp_have && ordy) exp_have = 0;
            if (fire) begin
                beats.push_back(p - n);
                if (beats.size() == BEATS) begin
                    s = 0;
                    foreach (beats[i]) s += beats[i];
                    exp_sum  = s;
                    exp_tern = tern_of(s, hi_i, lo_i);
                    exp_have = 1;
                    beats.delete();
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic feed(input int count, input int p, input int n);
        for (int i = 0; i < count; i++) cyc(1, p, n, 1, 0);
    endtask

    initial begin
        rst_n = 0; clr = 0; in_valid = 0; in_pos = 0; in_neg = 0; out_ready = 0;
        set_thr(10, -10);
        exp_have = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_tern", int'(out_tern), 0);
        chk("rst_out_sum", int'($signed(out_sum)), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1;
        @(posedge clk); #1;

        // reset mid-accumulation
        feed(2, 1, 0);
        in_valid = 0;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_tern", int'(out_tern), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        beats.delete(); exp_have = 0;
        rst_n = 1;
        @(posedge clk); #1;
        feed(4, 1, 0);
        chk("after_rst_sum", int'($signed(out_sum)), 4);
        cyc(0, 0, 0, 1, 0);

        // positive result, then hold under backpressure
        feed(4, 14, 0);
        chk("pos_valid", int'(out_valid), 1);
        chk("pos_sum", int'($signed(out_sum)), 56);
        chk("pos_tern", int'(out_tern), 1);
        for (int i = 0; i < 5; i++) cyc(1, 2, 0, 0, 0);
        // consume together with beat 0 of the negative neuron
        cyc(1, 0, 15, 1, 0);
        feed(3, 0, 15);
        chk("neg_sum", int'($signed(out_sum)), -60);
        chk("neg_tern", int'(out_tern), 3);
        // back-to-back dead-band neuron
        feed(4, 3, 1);
        chk("dead_sum", int'($signed(out_sum)), 8);
        chk("dead_tern", int'(out_tern), 0);
        cyc(0, 0, 0, 1, 0);

        // threshold equality and just-below boundary
        set_thr(8, -10);
        feed(4, 3, 1);
        chk("eq_hi_tern", int'(out_tern), 0);
        cyc(0, 0, 0, 1, 0);
        set_thr(20, 8);
        feed(4, 3, 1);
        chk("eq_lo_tern", int'(out_tern), 0);
        cyc(0, 0, 0, 1, 0);
        set_thr(20, 9);
        feed(4, 3, 1);
        chk("below_lo_tern", int'(out_tern), 3);
        cyc(0, 0, 0, 1, 0);
        set_thr(10, -10);

        // clr with the final beat discards the whole neuron
        feed(3, 5, 0);
        cyc(1, 5, 0, 1, 1);
        chk("clr_final_valid", int'(out_valid), 0);
        feed(4, 1, 2);
        chk("clr_next_sum", int'($signed(out_sum)), -4);
        // clr while a result is held drops it
        cyc(0, 0, 0, 0, 1);
        chk("clr_done_valid", int'(out_valid), 0);
        chk("clr_done_ready", int'(in_ready), 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                int a, b;
                a = int'($urandom_range(60)) - 30;
                b = int'($urandom_range(60)) - 30;
                if (a < b) set_thr(b, a); else set_thr(a, b);
            end
            cyc($urandom_range(3) != 0, int'($urandom_range(15)), int'($urandom_range(15)),
                $urandom_range(9) < 7, $urandom_range(31) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
